// File: rtl/ctrl_pkg.sv
// Shared opcode constants, history-entry type and controller states for the
// forwarding/hazard unit.
package ctrl_pkg;

  // Widest register address the history entries can hold; narrower RSIZE
  // values are zero-extended into this field.
  localparam int RD_W_MAX = 8;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic                valid;
    logic                is_load;
    logic [RD_W_MAX-1:0] rd;
  } hist_entry_t;

  function automatic logic op_writes(input logic [3:0] op);
    return (op <= 4'h8) || (op == 4'hA) || (op == 4'hB) || (op == 4'hD);
  endfunction

  function automatic logic op_uses_rs(input logic [3:0] op);
    return (op <= 4'h9);
  endfunction

  // Rt port reads the rt field for ALU ops
  function automatic logic op_rt_from_rt(input logic [3:0] op);
    return (op <= 4'h4);
  endfunction

  // Rt port reads the rd field (store data, compare-style ops)
  function automatic logic op_rt_from_rd(input logic [3:0] op);
    return (op == 4'h9) || (op == 4'hA) || (op == 4'hE) || (op == 4'hF);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority match of one decode-stage source against the producer history.
// The youngest matching producer (lowest slot) wins.
module fwd_match
  import ctrl_pkg::*;
#(
  parameter int RSIZE     = 4,
  parameter int FWD_DEPTH = 2
) (
  input  logic [RSIZE-1:0]    i_src,
  input  logic                i_src_used,
  input  logic [FWD_DEPTH-1:0] i_valid,
  input  logic [RD_W_MAX-1:0] i_rd [FWD_DEPTH],
  output logic [2:0]          o_sel
);

  logic [RD_W_MAX-1:0] w_src_ext;
  assign w_src_ext = RD_W_MAX'(i_src);

  // Scan oldest to youngest so the youngest hit overwrites older ones
  always_comb begin
    o_sel = 3'd0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (i_src_used && (i_src != '0) && i_valid[k] && (i_rd[k] == w_src_ext)) begin
        o_sel = 3'(k + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use / branch-flush hazard controller.
// Optional feature: define LOAD_USE_STALL_EN to enable the one-cycle
// load-use stall; without it stall is tied low and loads forward like ALU ops.
//
// state    | meaning
// ST_RUN   | normal issue, decode instruction may advance
// ST_STALL | bubble cycle after a load-use hit, load now sits in slot 1
// ST_FLUSH | remaining squash cycles after a taken branch
module fwd_hazard_unit
  import ctrl_pkg::*;
#(
  parameter int ISIZE        = 16,
  parameter int RSIZE        = 4,
  parameter int FWD_DEPTH    = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_opcode,
  input  logic [RSIZE-1:0] id_rd,
  input  logic [RSIZE-1:0] id_rs,
  input  logic [RSIZE-1:0] id_rt,
  input  logic             ex_br_taken,
  output logic [2:0]       fwd_rs_sel,
  output logic [2:0]       fwd_rt_sel,
  output logic             stall,
  output logic             flush,
  output logic [1:0]       state
);

  // Parameter sanity: opcode plus three register fields must fit an instruction
  generate
    if (ISIZE < 4 + 3 * RSIZE) begin : g_bad_isize
      $error("fwd_hazard_unit: ISIZE too small for opcode and register fields");
    end
    if (RSIZE > RD_W_MAX) begin : g_bad_rsize
      $error("fwd_hazard_unit: RSIZE exceeds history rd field");
    end
    if (FWD_DEPTH < 1 || FWD_DEPTH > 4) begin : g_bad_depth
      $error("fwd_hazard_unit: FWD_DEPTH out of range 1..4");
    end
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 4) begin : g_bad_flush
      $error("fwd_hazard_unit: FLUSH_CYCLES out of range 1..4");
    end
  endgenerate

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  hist_entry_t         r_hist [FWD_DEPTH];
  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_flush_cnt;
  logic [1:0]          w_flush_cnt_nxt;
  logic                w_flush;
  logic                w_stall;
  logic                w_rs_used;
  logic                w_rt_used;
  logic [RSIZE-1:0]    w_rt_src;
  logic                w_hist_load;
  logic [FWD_DEPTH-1:0] w_hist_valid;
  logic [RD_W_MAX-1:0] w_hist_rd [FWD_DEPTH];

  assign w_rs_used = id_valid && op_uses_rs(id_opcode);
  assign w_rt_used = id_valid && (op_rt_from_rt(id_opcode) || op_rt_from_rd(id_opcode));
  assign w_rt_src  = op_rt_from_rd(id_opcode) ? id_rd : id_rt;

  // Flatten history fields for the matchers
  always_comb begin
    for (int k = 0; k < FWD_DEPTH; k++) begin
      w_hist_valid[k] = r_hist[k].valid;
      w_hist_rd[k]    = r_hist[k].rd;
    end
  end

  fwd_match #(.RSIZE(RSIZE), .FWD_DEPTH(FWD_DEPTH)) u_match_rs (
    .i_src      (id_rs),
    .i_src_used (w_rs_used),
    .i_valid    (w_hist_valid),
    .i_rd       (w_hist_rd),
    .o_sel      (fwd_rs_sel)
  );

  fwd_match #(.RSIZE(RSIZE), .FWD_DEPTH(FWD_DEPTH)) u_match_rt (
    .i_src      (w_rt_src),
    .i_src_used (w_rt_used),
    .i_valid    (w_hist_valid),
    .i_rd       (w_hist_rd),
    .o_sel      (fwd_rt_sel)
  );

  assign w_flush = ex_br_taken || (r_state == ST_FLUSH);

`ifdef LOAD_USE_STALL_EN
  // A slot-0 hit is by construction valid, used and non-zero; flush wins
  assign w_stall = !w_flush && r_hist[0].is_load &&
                   ((fwd_rs_sel == 3'd1) || (fwd_rt_sel == 3'd1));
`else
  assign w_stall = 1'b0;
`endif

  assign w_hist_load = id_valid && op_writes(id_opcode) && !w_stall && !w_flush;

  // History shift register; slot 0 receives the issuing instruction or a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        r_hist[k] <= '0;
      end
    end else begin
      for (int k = FWD_DEPTH - 1; k > 0; k--) begin
        r_hist[k] <= r_hist[k-1];
      end
      r_hist[0].valid   <= w_hist_load;
      r_hist[0].is_load <= (id_opcode == OP_LW);
      r_hist[0].rd      <= RD_W_MAX'(id_rd);
    end
  end

  // State register and flush down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // Next-state: a taken branch restarts the flush window from any state
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    if (ex_br_taken) begin
      if (FLUSH_CYCLES > 1) begin
        w_state_nxt     = ST_FLUSH;
        w_flush_cnt_nxt = FLUSH_RELOAD;
      end else begin
        w_state_nxt     = ST_RUN;
        w_flush_cnt_nxt = 2'd0;
      end
    end else begin
      case (r_state)
        ST_FLUSH: begin
          if (r_flush_cnt <= 2'd1) begin
            w_state_nxt     = ST_RUN;
            w_flush_cnt_nxt = 2'd0;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - 2'd1;
          end
        end
        ST_STALL: w_state_nxt = ST_RUN;
        default:  w_state_nxt = w_stall ? ST_STALL : ST_RUN;
      endcase
    end
  end

  // Outputs
  always_comb begin
    stall = w_stall;
    flush = w_flush;
    state = r_state;
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios followed by
// randomized traffic, all checked against a producer-list reference model.
module tb_fwd_hazard_unit;

  localparam int D  = 2;
  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_opcode;
  logic [3:0] id_rd, id_rs, id_rt;
  logic       ex_br_taken;
  logic [2:0] fwd_rs_sel, fwd_rt_sel;
  logic       stall, flush;
  logic [1:0] state;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: list of in-flight producers, youngest first
  int m_valid [D];
  int m_rd    [D];
  int m_load  [D];
  int m_flush_left = 0;
  int m_stalled    = 0;

  fwd_hazard_unit #(.ISIZE(16), .RSIZE(4), .FWD_DEPTH(D), .FLUSH_CYCLES(FC)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_opcode   (id_opcode),
    .id_rd       (id_rd),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_br_taken (ex_br_taken),
    .fwd_rs_sel  (fwd_rs_sel),
    .fwd_rt_sel  (fwd_rt_sel),
    .stall       (stall),
    .flush       (flush),
    .state       (state)
  );

  always #5 clk = ~clk;

  function automatic int producer_for(input int src, input int used);
    if (used == 0 || src == 0) return 0;
    for (int k = 0; k < D; k++)
      if (m_valid[k] != 0 && m_rd[k] == src) return k + 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One cycle: drive, compare against model (and optional fixed values), advance
  task automatic step(input bit r, input bit v, input int op, input int rd,
                      input int rs, input int rt, input bit br, input string tag,
                      input int x_rs = -1, input int x_rt = -1, input int x_stall = -1,
                      input int x_flush = -1, input int x_state = -1);
    int e_rs, e_rt, e_stall, e_flush, e_state, rs_used, rt_used, rt_src, wr;
    rst = r; id_valid = v; id_opcode = 4'(op); id_rd = 4'(rd);
    id_rs = 4'(rs); id_rt = 4'(rt); ex_br_taken = br;
    #3;
    rs_used = (v && op inside {[0:9]}) ? 1 : 0;
    rt_used = (v && op inside {[0:4], 9, 10, 14, 15}) ? 1 : 0;
    rt_src  = (op inside {9, 10, 14, 15}) ? rd : rt;
    wr      = (op inside {[0:8], 10, 11, 13}) ? 1 : 0;
    e_rs    = producer_for(rs, rs_used);
    e_rt    = producer_for(rt_src, rt_used);
    e_flush = (br || m_flush_left > 0) ? 1 : 0;
`ifdef LOAD_USE_STALL_EN
    e_stall = (!e_flush && m_valid[0] != 0 && m_load[0] != 0 && (e_rs == 1 || e_rt == 1)) ? 1 : 0;
`else
    e_stall = 0;
`endif
    e_state = (m_flush_left > 0) ? 2 : (m_stalled != 0) ? 1 : 0;
    chk({tag, ".rs_sel"}, int'(fwd_rs_sel), e_rs);
    chk({tag, ".rt_sel"}, int'(fwd_rt_sel), e_rt);
    chk({tag, ".stall"},  int'(stall),      e_stall);
    chk({tag, ".flush"},  int'(flush),      e_flush);
    chk({tag, ".state"},  int'(state),      e_state);
    if (x_rs    >= 0) chk({tag, ".fix_rs_sel"}, int'(fwd_rs_sel), x_rs);
    if (x_rt    >= 0) chk({tag, ".fix_rt_sel"}, int'(fwd_rt_sel), x_rt);
    if (x_stall >= 0) chk({tag, ".fix_stall"},  int'(stall),      x_stall);
    if (x_flush >= 0) chk({tag, ".fix_flush"},  int'(flush),      x_flush);
    if (x_state >= 0) chk({tag, ".fix_state"},  int'(state),      x_state);
    if (r) begin
      for (int k = 0; k < D; k++) begin m_valid[k] = 0; m_rd[k] = 0; m_load[k] = 0; end
      m_flush_left = 0;
      m_stalled    = 0;
    end else begin
      for (int k = D - 1; k > 0; k--) begin
        m_valid[k] = m_valid[k-1]; m_rd[k] = m_rd[k-1]; m_load[k] = m_load[k-1];
      end
      m_valid[0]   = (v && wr && !e_stall && !e_flush) ? 1 : 0;
      m_rd[0]      = rd;
      m_load[0]    = (op == 8) ? 1 : 0;
      m_flush_left = br ? FC - 1 : (m_flush_left > 0 ? m_flush_left - 1 : 0);
      m_stalled    = e_stall;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < D; k++) begin m_valid[k] = 0; m_rd[k] = 0; m_load[k] = 0; end
    rst = 1'b1; id_valid = 1'b0; id_opcode = 4'h0; id_rd = 4'h0;
    id_rs = 4'h0; id_rt = 4'h0; ex_br_taken = 1'b0;
    @(posedge clk); #1;

    // reset state
    step(1, 0, 0, 0, 0, 0, 0, "rst0");
    step(0, 0, 0, 0, 0, 0, 0, "after_rst", 0, 0, 0, 0, 0);

    // back-to-back ALU dependency forwards from slot 0 on both ports
    step(0, 1, 0, 1, 2, 3, 0, "add_r1");
    step(0, 1, 0, 4, 1, 1, 0, "add_r4_r1_r1", 1, 1, 0, 0, 0);

    // dependency two back, r0 source never forwards
    step(0, 1, 0, 1, 2, 3, 0, "add_r1b");
    step(0, 1, 0, 6, 7, 8, 0, "add_r6");
    step(0, 1, 1, 5, 1, 0, 0, "sub_r5_r1_r0", 2, 0, 0, 0, 0);

    // load-use
    step(0, 1, 8, 2, 0, 0, 0, "lw_r2");
`ifdef LOAD_USE_STALL_EN
    step(0, 1, 0, 3, 2, 4, 0, "ld_use_stall", 1, 0, 1, 0, 0);
    step(0, 1, 0, 3, 2, 4, 0, "ld_use_retry", 2, 0, 0, 0, 1);
`else
    step(0, 1, 0, 3, 2, 4, 0, "ld_use_fwd", 1, 0, 0, 0, 0);
`endif

    // branch together with load-use: flush wins, two flush cycles, consumer squashed
    step(0, 1, 8, 2, 0, 0, 0, "lw_r2b");
    step(0, 1, 0, 3, 2, 4, 1, "br_and_ld_use", -1, -1, 0, 1, 0);
    step(0, 1, 0, 9, 3, 0, 0, "flush_cycle2", 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 0, 0, "flush_done", 0, 0, 0, 0, 0);

    // youngest producer wins on the store-data port
    step(0, 1, 8, 1, 0, 0, 0, "lw_r1");
    step(0, 1, 0, 1, 0, 0, 0, "add_r1c");
    step(0, 1, 9, 1, 0, 0, 0, "sw_r1", 0, 1, 0, 0, 0);

    // reset in the middle of a flush window, also overriding a taken branch
    step(0, 1, 0, 1, 0, 0, 0, "add_r1d");
    step(0, 0, 0, 0, 0, 0, 1, "br_again", -1, -1, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, "rst_in_flush", -1, -1, -1, 1, 2);
    step(0, 1, 0, 4, 1, 1, 0, "post_rst", 0, 0, 0, 0, 0);

    // a second branch inside the flush window restarts the count
    step(0, 0, 0, 0, 0, 0, 1, "br_first", -1, -1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, "br_reload", -1, -1, 0, 1, 2);
    step(0, 0, 0, 0, 0, 0, 0, "reload_tail", -1, -1, 0, 1, 2);
    step(0, 0, 0, 0, 0, 0, 0, "reload_end", -1, -1, 0, 0, 0);

    // randomized traffic with small register range for frequent hits
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 5)),
           int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
           ($urandom_range(0, 7) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter ISIZE, 16, instruction width in bits.
REQ-002 Parameter RSIZE, 4, register address width in bits.
REQ-003 Parameter FWD_DEPTH, 2, number of in-flight producer stages tracked (range 1..4).
REQ-004 Parameter FLUSH_CYCLES, 2, cycles flush is asserted per taken branch (range 1..4).
REQ-005 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 Port rst  in  1  synchronous, active-high reset.
REQ-007 Port id_valid  in  1  decode-stage instruction is valid.
REQ-008 Port id_opcode  in  4  decode-stage opcode.
REQ-009 Ports id_rd, id_rs, id_rt  in  RSIZE each  decode-stage register fields.
REQ-010 Port ex_br_taken  in  1  branch/jump resolved taken in EX this cycle.
REQ-011 Ports fwd_rs_sel, fwd_rt_sel  out  3 each  0 = register file, k = result of history slot k-1.
REQ-012 Port stall  out  1  hold PC and IF/ID, insert bubble into EX.
REQ-013 Port flush  out  1  squash IF/ID contents.
REQ-014 Port state  out  2  RUN=0, STALL=1, FLUSH=2.

Function
REQ-015 History hist[0..FWD_DEPTH-1] of {valid, rd, is_load}; hist[0] is the EX-stage instruction; shifts hist[k]<=hist[k-1] every cycle.
REQ-016 hist[0] loads {1, id_rd, opcode==LW} when id_valid, opcode writes, stall=0 and flush=0; otherwise loads valid=0.
REQ-017 Writing opcodes: 0x0-0x8, 0xA, 0xB, 0xD; all others non-writing.
REQ-018 Rs source used for opcodes 0x0-0x9; Rt-port source is id_rt for 0x0-0x4, id_rd for 0x9, 0xA, 0xE, 0xF; unused otherwise.
REQ-019 fwd_*_sel = k+1 for the smallest k with hist[k].valid, hist[k].rd==source, source!=0, source used; else 0 (youngest wins).
REQ-020 Load-use: hist[0].valid, hist[0].is_load, match on a used source !=0 -> stall=1 combinationally, state RUN->STALL.
REQ-021 STALL lasts exactly one cycle, then RUN; the consumer then sees the load in hist[1] and forwards sel=2.
REQ-022 ex_br_taken -> flush=1 the same cycle and for FLUSH_CYCLES-1 further cycles; state ->FLUSH with down-counter when FLUSH_CYCLES>1.
REQ-023 Flush has priority over stall: simultaneous event gives stall=0, flush=1, no STALL entry.
REQ-024 ex_br_taken while in FLUSH reloads the counter to FLUSH_CYCLES-1.
REQ-025 During flush or stall, forward selects remain computed but the consumer is not committed.

Reset
REQ-026 rst: all hist valid=0, state=RUN, flush counter=0; outputs stall=0, flush=0, fwd_rs_sel=0, fwd_rt_sel=0 the cycle after rst.
REQ-027 rst mid-FLUSH or mid-STALL aborts to RUN immediately; rst dominates ex_br_taken.

Configuration
REQ-028 Macro LOAD_USE_STALL_EN: defined -> REQ-020/021 active; undefined -> stall tied 0, STALL state unreachable, load results forward like ALU results.

Structure
REQ-029 Package ctrl_pkg holds opcode constants, hist-entry typedef, state enumeration.
REQ-030 Sub-module fwd_match (priority match of one source against history) instantiated twice.

Verification
REQ-031 ADD r1,r2,r3 then ADD r4,r1,r1 -> fwd_rs_sel=1, fwd_rt_sel=1.
REQ-032 ADD r1; NOP-less unrelated; SUB r5,r1,r0 (FWD_DEPTH=2) -> fwd_rs_sel=2; src r0 -> sel=0.
REQ-033 LW r2 then ADD r3,r2,r4 with LOAD_USE_STALL_EN -> stall=1 one cycle, state=STALL, next cycle fwd_rs_sel=2.
REQ-034 ex_br_taken=1 and load-use same cycle, FLUSH_CYCLES=2 -> flush=1 two cycles, stall=0, hist[0] invalid.
REQ-035 ADD r1 into slot 0 and LW r1 in slot 1, SW rd=r1 -> fwd_rt_sel=1 (youngest).
REQ-036 rst asserted during FLUSH -> next cycle state=RUN, flush=0, all selects 0.
